// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with stall hold, redirect and kill of stale responses
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallF,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        fetch_valid,
    output logic [31:0] InstructionF,
    output logic [31:0] PCPlus4F
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, ibuf_q, ibuf_d;
    logic        kill_q, kill_d;
    // next-state: redirect always wins; a redirect while waiting marks the in-flight response stale
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ibuf_d  = ibuf_q;
        kill_d  = kill_q;
        case (state_q)
            S_REQ: begin
                if (redirect) pc_d = redirect_pc;
                else if (imem_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (kill_q || redirect) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                        pc_d    = redirect ? redirect_pc : pc_q;
                    end else begin
                        ibuf_d  = imem_rdata;
                        state_d = S_HOLD;
                    end
                end else if (redirect) begin
                    pc_d   = redirect_pc;
                    kill_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = S_REQ;
                end else if (!stallF) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end
    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            ibuf_q  <= 32'h0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ibuf_q  <= ibuf_d;
            kill_q  <= kill_d;
        end
    end
    assign imem_req     = (state_q == S_REQ) && !redirect;
    assign imem_addr    = pc_q;
    assign fetch_valid  = (state_q == S_HOLD);
    assign InstructionF = fetch_valid ? ibuf_q : 32'h0;
    assign PCPlus4F     = pc_q + 32'd4;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus random traffic checked against a transaction-level fetch model
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst, stallF, redirect, imem_ready, imem_rvalid;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, fetch_valid;
    logic [31:0] imem_addr, InstructionF, PCPlus4F;

    fetch_unit #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .stallF(stallF), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .fetch_valid(fetch_valid),
        .InstructionF(InstructionF), .PCPlus4F(PCPlus4F)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // memory: one response per accepted request after lat_min..lat_max idle cycles
    bit          mem_busy = 0;
    logic [31:0] mem_addr;
    int          mem_cnt, lat_min = 0, lat_max = 0;
    bit          spurious_en = 0;

    // reference model: pc, whether a response is owed, whether it is stale, buffered word
    bit          m_init = 0;
    logic [31:0] m_pc, m_buf;
    bit          m_infl, m_stale, m_valid;

    int          cyc = 0;
    bit          obs_req [0:63];
    bit          obs_fv  [0:63];
    logic [31:0] obs_addr[0:63];
    logic [31:0] obs_ins [0:63];
    logic [31:0] obs_p4  [0:63];

    task automatic step(input bit r, input bit st, input bit rd, input logic [31:0] rpc, input bit rdy);
        bit exp_req, delivered;
        @(negedge clk);
        rst = r; stallF = st; redirect = rd; redirect_pc = rpc; imem_ready = rdy;
        delivered   = mem_busy && mem_cnt == 0;
        imem_rvalid = delivered;
        imem_rdata  = mem_busy ? (mem_addr ^ 32'hA5A5_0000) : $urandom;
        if (!mem_busy && spurious_en && $urandom_range(0, 7) == 0) imem_rvalid = 1'b1;
        exp_req = !m_infl && !m_valid && !rd;
        #1;
        if (cyc < 64) begin
            obs_req[cyc] = imem_req; obs_fv[cyc] = fetch_valid; obs_addr[cyc] = imem_addr;
            obs_ins[cyc] = InstructionF; obs_p4[cyc] = PCPlus4F;
        end
        if (m_init) begin
            check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
            check("imem_addr", imem_addr, m_pc);
            check("fetch_valid", {31'b0, fetch_valid}, {31'b0, m_valid});
            check("InstructionF", InstructionF, m_valid ? m_buf : 32'h0);
            check("PCPlus4F", PCPlus4F, m_pc + 32'd4);
        end
        @(posedge clk);
        if (delivered) mem_busy = 0;
        else if (mem_busy) mem_cnt--;
        if (exp_req && rdy) begin
            mem_busy = 1; mem_addr = m_pc; mem_cnt = $urandom_range(lat_min, lat_max);
        end
        if (r) begin
            m_init = 1; m_pc = 32'h0; m_infl = 0; m_stale = 0; m_valid = 0;
        end else if (m_valid) begin
            if (rd) begin m_pc = rpc; m_valid = 0; end
            else if (!st) begin m_pc = m_pc + 32'd4; m_valid = 0; end
        end else if (m_infl) begin
            if (imem_rvalid) begin
                m_infl = 0;
                if (m_stale || rd) begin m_stale = 0; if (rd) m_pc = rpc; end
                else begin m_valid = 1; m_buf = imem_rdata; end
            end else if (rd) begin
                m_pc = rpc; m_stale = 1;
            end
        end else begin
            if (rd) m_pc = rpc;
            else if (rdy) m_infl = 1;
        end
        cyc++;
    endtask

    initial begin
        step(1, 0, 0, 0, 1);
        for (int i = 1; i <= 8; i++) step(0, 0, 0, 0, 1);
        for (int i = 9; i <= 12; i++) step(0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        lat_min = 1; lat_max = 1;
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 32'h100, 1);
        lat_min = 0; lat_max = 0;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 32'h200, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 1, 1, 32'hFFFF_FFFC, 1);
        for (int i = 22; i <= 24; i++) step(0, 0, 0, 0, 0);
        for (int i = 25; i <= 27; i++) step(0, 0, 0, 0, 1);
        lat_min = 1; lat_max = 1;
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        check("rst_req", {31'b0, obs_req[1]}, 32'd1);
        check("rst_p4", obs_p4[1], 32'd4);
        check("sl_ins0", obs_ins[3], 32'hA5A5_0000);
        check("sl_ins4", obs_ins[6], 32'hA5A5_0004);
        check("sl_fv_gap", {31'b0, obs_fv[7]}, 32'd0);
        for (int i = 9; i <= 12; i++) begin
            check("stall_fv", {31'b0, obs_fv[i]}, 32'd1);
            check("stall_ins", obs_ins[i], 32'hA5A5_0008);
            check("stall_req", {31'b0, obs_req[i]}, 32'd0);
        end
        check("stall_next", obs_addr[14], 32'd12);
        check("rdw_fv", {31'b0, obs_fv[16]}, 32'd0);
        check("rdw_addr", obs_addr[17], 32'h100);
        check("rdv_addr", obs_addr[19], 32'h200);
        check("rdh_addr", obs_addr[22], 32'hFFFF_FFFC);
        check("bp_req", {31'b0, obs_req[24]}, 32'd1);
        check("wrap_ins", obs_ins[27], 32'h5A5A_FFFC);
        check("wrap_p4", obs_p4[27], 32'h0);
        check("wrap_addr", obs_addr[28], 32'h0);
        check("rstw_fv", {31'b0, obs_fv[31]}, 32'd0);
        check("rstw_req", {31'b0, obs_req[31]}, 32'd1);

        lat_min = 0; lat_max = 3; spurious_en = 1;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            step($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 6) == 0, rpc, $urandom_range(0, 3) != 0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
